// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, runs a single-outstanding req/ack fetch to instruction
// memory, holds one fetched instruction for decode, and applies branch/trap redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_br_sel,
  input  logic [31:0] i_pc_bru,
  input  logic        i_trap,
  input  logic [31:0] i_trap_vec,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_flush
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        vld_q, vld_d;
  logic        flush_q, flush_d;

  logic        consume;
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;

  assign consume    = vld_q & ~i_stall;
  assign redirect   = (i_trap | i_br_sel) & (state_q != StIdle);
  assign target_raw = i_trap ? i_trap_vec : i_pc_bru;
  assign target     = {target_raw[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    vld_d     = vld_q;
    flush_d   = 1'b0;

    if (consume) begin
      vld_d = 1'b0;
    end

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redirect) begin
          // An ack in the redirect cycle retires the stale request, so no drain is needed.
          state_d = i_imem_ack ? StReq : StDrain;
        end else if (i_imem_ack) begin
          if (!vld_q || !i_stall) begin
            inst_d    = i_imem_rdata;
            inst_pc_d = pc_q;
            vld_d     = 1'b1;
            pc_d      = pc_q + 32'd4;
            state_d   = i_stall ? StWait : StReq;
          end else begin
            // Slot still held by a stalled decode: drop the word and refetch the same PC later.
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (redirect || consume) begin
          state_d = StReq;
        end
      end
      StDrain: begin
        if (i_imem_ack) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      pc_d    = target;
      vld_d   = 1'b0;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      vld_q     <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      vld_q     <= vld_d;
      flush_q   <= flush_d;
    end
  end

  assign o_imem_req  = (state_q == StReq);
  assign o_imem_addr = pc_q;
  assign o_inst_vld  = vld_q;
  assign o_inst      = inst_q;
  assign o_pc        = inst_pc_q;
  assign o_flush     = flush_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer: one record per clock cycle, plus a
// hand-written asynchronous-reset sequence.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_sel, trap, imem_ack;
  logic [31:0] pc_bru, trap_vec, imem_rdata;
  logic        imem_req, inst_vld, flush;
  logic [31:0] imem_addr, inst, pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_br_sel     (br_sel),
    .i_pc_bru     (pc_bru),
    .i_trap       (trap),
    .i_trap_vec   (trap_vec),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_inst_vld   (inst_vld),
    .o_inst       (inst),
    .o_pc         (pc),
    .o_flush      (flush)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bru;
    logic        trap;
    logic [31:0] vec;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_flush;
  } vec_t;

  localparam int NumVec = 20;
  vec_t tv[NumVec];

  task automatic check_out(input string name, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_inst, input logic [31:0] e_pc,
                           input logic e_flush);
    checks++;
    if (imem_req !== e_req || imem_addr !== e_addr || inst_vld !== e_vld || inst !== e_inst ||
        pc !== e_pc || flush !== e_flush) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h vld=%b inst=%h pc=%h flush=%b want req=%b addr=%h vld=%b inst=%h pc=%h flush=%b",
               name, imem_req, imem_addr, inst_vld, inst, pc, flush,
               e_req, e_addr, e_vld, e_inst, e_pc, e_flush);
    end
  endtask

  initial begin
    //          stall br bru           trap vec           ack rdata            req addr          vld inst           pc             fl
    tv[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tv[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h1111_0000, 1'b1, 32'h0,       1'b0, 32'h0,        32'h0,        1'b0};
    tv[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h1111_0004, 1'b1, 32'h4,       1'b1, 32'h1111_0000, 32'h0,       1'b0};
    tv[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h1111_0008, 1'b1, 32'h8,       1'b1, 32'h1111_0004, 32'h4,       1'b0};
    tv[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h1111_000C, 1'b1, 32'hC,       1'b1, 32'h1111_0008, 32'h8,       1'b0};
    tv[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 32'h1111_0008, 32'h8,       1'b0};
    tv[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 32'h1111_0008, 32'h8,       1'b0};
    tv[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 32'h1111_0008, 32'h8,       1'b0};
    tv[8]  = '{1'b0, 1'b1, 32'h100,      1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h1111_0008, 32'h8,       1'b0};
    tv[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h100,     1'b0, 32'h1111_0008, 32'h8,       1'b1};
    tv[10] = '{1'b0, 1'b1, 32'h200,      1'b1, 32'h40, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'h100,     1'b0, 32'h1111_0008, 32'h8,       1'b0};
    tv[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h2222_0040, 1'b1, 32'h40,      1'b0, 32'h1111_0008, 32'h8,       1'b1};
    tv[12] = '{1'b0, 1'b1, 32'h103,      1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h44,       1'b1, 32'h2222_0040, 32'h40,      1'b0};
    tv[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 32'h100,      1'b0, 32'h2222_0040, 32'h40,      1'b1};
    tv[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h2222_0040, 32'h40,    1'b1};
    tv[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h3333_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h2222_0040, 32'h40,    1'b0};
    tv[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h3333_FFFC, 32'hFFFF_FFFC, 1'b0};
    tv[17] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h1234_5678, 1'b1, 32'h0,       1'b1, 32'h3333_FFFC, 32'hFFFF_FFFC, 1'b0};
    tv[18] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b1, 32'h0BAD_F00D, 1'b0, 32'h0,       1'b1, 32'h3333_FFFC, 32'hFFFF_FFFC, 1'b0};
    tv[19] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h3333_FFFC, 32'hFFFF_FFFC, 1'b0};

    rst_n = 1'b0;
    stall = 1'b0; br_sel = 1'b0; trap = 1'b0; imem_ack = 1'b0;
    pc_bru = 32'h0; trap_vec = 32'h0; imem_rdata = 32'h0;
    #1;
    check_out("reset_state", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      stall      = tv[i].stall;
      br_sel     = tv[i].br;
      pc_bru     = tv[i].bru;
      trap       = tv[i].trap;
      trap_vec   = tv[i].vec;
      imem_ack   = tv[i].ack;
      imem_rdata = tv[i].rdata;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_vld, tv[i].e_inst,
                tv[i].e_pc, tv[i].e_flush);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-WAIT with the slot full.
    stall = 1'b1; imem_ack = 1'b0; br_sel = 1'b0; trap = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1 check_out("reset_held", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    check_out("post_reset_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_out("post_reset_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
